// File: rtl/ram_bank16_if.sv
// ram_bank16_if: request/acknowledge bus for the sixteen-word storage bank.
//   sel    [0:15]  one-hot word select; sel[0] is word 0 and sel[15] is word 15
//   req, we, wdata  request, direction and write data, all captured together
//   ready          bank idle; req is sampled only while this is high
//   ack            one-cycle completion pulse
//   err            select-vector fault, meaningful only while ack is high
//   rdata          read data register, held after ack
// modports: master = requester, slave = bank.
interface ram_bank16_if #(parameter int DATA_W = 8);
    logic [0:15]       sel;
    logic              req;
    logic              we;
    logic [DATA_W-1:0] wdata;
    logic              ready;
    logic              ack;
    logic              err;
    logic [DATA_W-1:0] rdata;

    modport master (output sel, req, we, wdata, input ready, ack, err, rdata);
    modport slave  (input sel, req, we, wdata, output ready, ack, err, rdata);
endinterface

// File: rtl/ram_bank16.sv
// ram_bank16: sixteen-word storage bank driven by a one-hot decoder select.
// Each access takes three states: IDLE (capture), ACCESS (check the select
// and do the read/write), RESP (one-cycle ack).
// Ports:
//   clk  rising-edge clock
//   rst  asynchronous active-high reset; clears state, rdata and all 16 words
//   bus  ram_bank16_if.slave (sel/req/we/wdata in, ready/ack/err/rdata out)
// Build option: define RAM_WRITE_THROUGH_EN so that a successful write also
// loads the written value into rdata, making it visible on the write's ack.
module ram_bank16 #(
    parameter int DATA_W = 8
) (
    input  logic         clk,
    input  logic         rst,
    ram_bank16_if.slave  bus
);
    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ACCESS = 2'd1;
    localparam logic [1:0] RESP   = 2'd2;

    logic [1:0]        state;
    logic [0:15]       sel_q;
    logic              we_q;
    logic [DATA_W-1:0] wdata_q;
    logic              err_q;
    logic [DATA_W-1:0] rdata_q;
    logic [DATA_W-1:0] mem [16];

    // Population count and index of the captured select. When exactly one
    // bit is set, idx is that bit's word number; otherwise idx is unused.
    logic [4:0] cnt;
    logic [3:0] idx;
    always_comb begin
        cnt = '0;
        idx = '0;
        for (int i = 0; i < 16; i++) begin
            if (sel_q[i]) begin
                cnt = cnt + 5'd1;
                idx = 4'(i);
            end
        end
    end

    wire one_hot = (cnt == 5'd1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            sel_q   <= '0;
            we_q    <= 1'b0;
            wdata_q <= '0;
            err_q   <= 1'b0;
            rdata_q <= '0;
            for (int i = 0; i < 16; i++) mem[i] <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.req) begin
                        sel_q   <= bus.sel;
                        we_q    <= bus.we;
                        wdata_q <= bus.wdata;
                        err_q   <= 1'b0;
                        state   <= ACCESS;
                    end
                end
                ACCESS: begin
                    // A zero or multi-hot select is a fault: memory and rdata
                    // stay untouched, only the error flag is raised.
                    err_q <= !one_hot;
                    if (one_hot) begin
                        if (we_q) begin
                            mem[idx] <= wdata_q;
`ifdef RAM_WRITE_THROUGH_EN
                            rdata_q  <= wdata_q;
`endif
                        end else begin
                            rdata_q <= mem[idx];
                        end
                    end
                    state <= RESP;
                end
                RESP:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Outputs come straight from state and registers; no input reaches an
    // output combinationally.
    assign bus.ready = (state == IDLE);
    assign bus.ack   = (state == RESP);
    assign bus.err   = (state == RESP) & err_q;
    assign bus.rdata = rdata_q;
endmodule

// File: tb/tb_ram_bank16.sv
// tb_ram_bank16: directed test of ram_bank16 against a transaction-level
// model (array memory plus a queue of expected acks with due cycles).
module tb_ram_bank16;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ram_bank16_if #(.DATA_W(8)) bus ();
    ram_bank16 #(.DATA_W(8)) dut (.clk(clk), .rst(rst), .bus(bus));

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
        end
    endtask

    // ---------------- model ----------------
    typedef struct {
        int         due;
        logic       e;
        logic [7:0] d;
    } exp_t;

    exp_t       q[$];
    logic [7:0] mem_m [16];
    logic [7:0] rdata_m;
    int         cyc = 0;
    bit         m_ready;
    int         m_cnt, m_k;
    exp_t       ent;

    // An access is pending from its acceptance edge through its ack cycle;
    // the bank only accepts when nothing was pending before the edge.
    always @(posedge clk) begin
        cyc++;
        if (rst) begin
            q.delete();
            for (int i = 0; i < 16; i++) mem_m[i] = 8'h00;
            rdata_m = 8'h00;
        end else begin
            m_ready = (q.size() == 0);
            if (q.size() > 0 && q[0].due < cyc) void'(q.pop_front());
            if (m_ready && bus.req) begin
                m_cnt = $countones(bus.sel);
                m_k = 0;
                for (int i = 0; i < 16; i++) if (bus.sel[i]) m_k = i;
                if (m_cnt == 1) begin
                    if (bus.we) begin
                        mem_m[m_k] = bus.wdata;
`ifdef RAM_WRITE_THROUGH_EN
                        rdata_m = bus.wdata;
`endif
                    end else begin
                        rdata_m = mem_m[m_k];
                    end
                end
                ent.due = cyc + 1;
                ent.e   = (m_cnt != 1);
                ent.d   = rdata_m;
                q.push_back(ent);
            end
        end
    end

    // Single compare process: every cycle out of reset.
    bit exp_ack;
    always @(negedge clk) begin
        if (!rst) begin
            exp_ack = (q.size() > 0) && (q[0].due == cyc);
            chk("ready", 32'(bus.ready), 32'(q.size() == 0));
            chk("ack", 32'(bus.ack), 32'(exp_ack));
            if (exp_ack) begin
                chk("err", 32'(bus.err), 32'(q[0].e));
                chk("rdata", 32'(bus.rdata), 32'(q[0].d));
            end
        end
    end

    // ---------------- driver ----------------
    function automatic logic [0:15] onehot(input int k);
        logic [0:15] s;
        s = '0;
        s[k] = 1'b1;
        return s;
    endfunction

    task automatic access(input logic [0:15] s, input logic w, input logic [7:0] d,
                          output logic [7:0] rd, output logic er, output int lat);
        bit got;
        @(negedge clk);
        bus.sel = s; bus.we = w; bus.wdata = d; bus.req = 1'b1;
        rd = 8'h00; er = 1'b0; lat = 0; got = 0;
        @(posedge clk);
        lat = 1;
        #1 bus.req = 1'b0;
        @(negedge clk);
        while (!got && lat < 10) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (bus.ack) begin
                got = 1;
                rd = bus.rdata;
                er = bus.err;
            end
        end
        if (!got) begin
            n_cmp++; n_err++;
            $display("FAIL ack_timeout: no ack within 10 cycles, expected one");
        end
    endtask

    logic [7:0] rd;
    logic       er;
    int         lat;
    int         acks[$];
    logic [0:15] s2;

    initial begin
        bus.sel = '0; bus.req = 1'b0; bus.we = 1'b0; bus.wdata = 8'h00;
        #1;
        chk("rst_ready", 32'(bus.ready), 32'd1);
        chk("rst_ack", 32'(bus.ack), 32'd0);
        chk("rst_rdata", 32'(bus.rdata), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1'b0;
        chk("ready_after_rst", 32'(bus.ready), 32'd1);

        // Every word reads zero after reset.
        for (int k = 0; k < 16; k++) begin
            access(onehot(k), 1'b0, 8'h00, rd, er, lat);
            chk("init_read", 32'(rd), 32'h00);
        end

        // Write/read word 3, plus latency.
        access(onehot(3), 1'b1, 8'hA5, rd, er, lat);
        chk("wr_latency", 32'(lat), 32'd2);
        access(onehot(3), 1'b0, 8'h00, rd, er, lat);
        chk("rd3_value", 32'(rd), 32'hA5);
        chk("rd3_err", 32'(er), 32'd0);
        chk("rd_latency", 32'(lat), 32'd2);
        access(onehot(4), 1'b0, 8'h00, rd, er, lat);
        chk("rd4_value", 32'(rd), 32'h00);

        // Faulted selects: none, and two bits.
        access(16'h0000, 1'b1, 8'h3C, rd, er, lat);
        chk("sel_zero_err", 32'(er), 32'd1);
        chk("sel_zero_rdata_kept", 32'(rd), 32'h00);
        for (int k = 0; k < 16; k++) access(onehot(k), 1'b0, 8'h00, rd, er, lat);
        s2 = onehot(1);
        s2[9] = 1'b1;
        access(s2, 1'b1, 8'h3C, rd, er, lat);
        chk("sel_multi_err", 32'(er), 32'd1);
        for (int k = 0; k < 16; k++) access(onehot(k), 1'b0, 8'h00, rd, er, lat);
        access(onehot(9), 1'b0, 8'h00, rd, er, lat);
        chk("rd9_after_fault", 32'(rd), 32'h00);

        // Hold req for 9 cycles: acks at 2, 5, 8.
        @(negedge clk);
        bus.sel = onehot(5); bus.we = 1'b0; bus.req = 1'b1;
        for (int i = 1; i <= 9; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (bus.ack) acks.push_back(i);
        end
        bus.req = 1'b0;
        chk("b2b_count", 32'(acks.size()), 32'd3);
        if (acks.size() == 3) begin
            chk("b2b_ack0", 32'(acks[0]), 32'd2);
            chk("b2b_ack1", 32'(acks[1]), 32'd5);
            chk("b2b_ack2", 32'(acks[2]), 32'd8);
        end
        repeat (3) @(posedge clk);

        // Reset during ACCESS of a read of word 7.
        access(onehot(7), 1'b1, 8'h5A, rd, er, lat);
        access(onehot(7), 1'b0, 8'h00, rd, er, lat);
        chk("rd7_before_rst", 32'(rd), 32'h5A);
        @(negedge clk);
        bus.sel = onehot(7); bus.we = 1'b0; bus.req = 1'b1;
        @(posedge clk);
        #1 bus.req = 1'b0;
        rst = 1'b1;
        #1;
        chk("midrst_ack", 32'(bus.ack), 32'd0);
        chk("midrst_rdata", 32'(bus.rdata), 32'h00);
        @(posedge clk);
        @(negedge clk) rst = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("midrst_no_ack", 32'(bus.ack), 32'd0);
        end
        access(onehot(7), 1'b0, 8'h00, rd, er, lat);
        chk("rd7_after_rst", 32'(rd), 32'h00);

        // Write-through behaviour on word 2.
        access(onehot(2), 1'b1, 8'h11, rd, er, lat);
        access(onehot(2), 1'b0, 8'h00, rd, er, lat);
        chk("rd2_value", 32'(rd), 32'h11);
        access(onehot(2), 1'b1, 8'hF0, rd, er, lat);
`ifdef RAM_WRITE_THROUGH_EN
        chk("wr2_ack_rdata", 32'(rd), 32'hF0);
`else
        chk("wr2_ack_rdata", 32'(rd), 32'h11);
`endif
        access(onehot(2), 1'b0, 8'h00, rd, er, lat);
        chk("rd2_new", 32'(rd), 32'hF0);

        repeat (2) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/ram_bank16.md
# ram_bank16

Sixteen-word storage bank that sits directly downstream of the 4-to-16 address decoder and consumes its one-hot word-select lines. A request/acknowledge handshake moves each access through a small state machine that validates the select vector, performs one write or read, and returns a one-cycle acknowledge with read data and an error flag. This is the working-memory stage of the microprocessor datapath.

## Interface
- DATA_W, default 8: word width in bits.
- clk  input  1  rising-edge clock.
- rst  input  1  reset; asynchronous, active-high.
- sel  input  [0:15]  one-hot word select from the decoder, already gated by the RAM enable; sel[0] selects word 0, sel[15] selects word 15.
- req  input  1  access request; sampled only while ready=1.
- we  input  1  1 = write, 0 = read; captured with req.
- wdata  input  DATA_W  write data; captured with req.
- ready  output  1  bank idle and able to accept req.
- ack  output  1  one-cycle pulse that completes an access.
- err  output  1  select-vector fault; valid only while ack=1.
- rdata  output  DATA_W  read data register; valid while ack=1 and held afterwards.

## Operation
- Storage: mem[0..15], each DATA_W bits.
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - ready=1.
  - When req=1, capture sel, we and wdata into holding registers, then go to ACCESS.
- ACCESS:
  - ready=0.
  - Compute the population count of the captured sel.
  - Count == 1, i.e. index k: a write stores wdata into mem[k]; a read loads mem[k] into rdata.
  - Count == 0 (decoder disabled) or count > 1: set the err register, leave memory and rdata unchanged.
  - Always go to RESP.
- RESP:
  - ack=1, err driven from the err register, ready=0.
  - Always return to IDLE.
- req is ignored while ready=0 and is never queued. A requester holding req high gets back-to-back accesses.
- The err register clears on entry to ACCESS.
- A write never modifies rdata, except under the macro described in Configuration.

## Timing
- req accepted on edge N; memory updated or rdata loaded on edge N+1; ack=1 during the cycle after edge N+1, deasserted at edge N+2.
- Request-to-ack latency: 2 cycles. Throughput: one access per 3 cycles.
- ready falls at edge N and rises again at edge N+2, so the next req is sampled at edge N+3.
- Combinational paths: none from inputs to outputs. All outputs are registered or decoded from state.
- Reset values, asserted asynchronously:
  - state=IDLE, ready=1, ack=0, err=0, rdata=0.
  - All 16 words cleared to 0; holding registers cleared.
- Reset mid-access (in ACCESS or RESP): the access is abandoned, no ack is produced, and memory is cleared.

## Configuration
- RAM_WRITE_THROUGH_EN defined: a successful write also loads wdata into rdata in ACCESS, so the write's ack presents the written value.
- RAM_WRITE_THROUGH_EN undefined: a write leaves rdata holding the previous read result.
- Faulted accesses (err=1) never change rdata in either build.

## Test plan
- Reset, then read every word with sel one-hot 0..15: each ack shows rdata=0 and err=0; ready=1 right after reset.
- Write 8'hA5 via sel[3]=1, then read via sel[3]: read ack shows rdata=8'hA5 and err=0. Ack arrives 2 cycles after each req; a read of sel[4] returns 8'h00.
- Write 8'h3C with sel=16'h0000 (decoder disabled): ack with err=1. A subsequent read of all words returns 0. Repeat with sel[1] and sel[9] both set: err=1, no word changes.
- Hold req=1 for 9 cycles doing reads: exactly 3 acks, at cycles 2, 5 and 8 after the first req. ready low during each access.
- Write 8'h5A to word 7, then assert rst during the ACCESS of a read of word 7: no ack is produced, rdata=0, and a post-reset read of word 7 returns 8'h00.
- Read word 2 (value 8'h11), then write 8'hF0 to word 2: the write's ack shows rdata=8'hF0 with RAM_WRITE_THROUGH_EN defined, and 8'h11 without it.
